booth_radix4_seq_mult: RTL and testbench

//  Iterative, parametrised radix-4 Booth multiplier. It retires one Booth digit per cycle

---
 rtl/booth_radix4_seq_mult.sv | 95 +++++++++
 tb/tb_booth_radix4_seq_mult.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/booth_radix4_seq_mult.sv
// booth_radix4_seq_mult: iterative radix-4 Booth multiplier, one digit per cycle, valid/ready on both sides.
// Define BOOTH_EARLY_TERM_EN to finish as soon as all remaining Booth digits are zero.
module booth_radix4_seq_mult #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH/2+2)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod
);
  localparam int EW = WIDTH+2;
  localparam int AW = 2*WIDTH+2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH/2);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [EW-1:0] a_q, a_d, b_q, b_d;
  logic [AW-1:0] acc_q, acc_d, a_x, mag, term;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] out_prod_q, out_prod_d;
  logic out_valid_q, out_valid_d, last;
  logic [2:0] trip;
`ifdef BOOTH_EARLY_TERM_EN
  logic signed [EW-1:0] hi;
`endif
  assign in_ready  = !rst && state_q == IDLE;
  assign out_valid = out_valid_q;
  assign out_prod  = out_prod_q;
  always_comb begin
    a_x  = {{WIDTH{a_q[EW-1]}}, a_q};
    // {b,0} supplies the implicit B'[-1]=0 below the multiplier
    trip = 3'({b_q, 1'b0} >> {cnt_q, 1'b0});
    mag  = trip == 3'b011 ? a_x << 1 :
           trip == 3'b100 ? -(a_x << 1) :
           (trip == 3'b001 || trip == 3'b010) ? a_x :
           (trip == 3'b101 || trip == 3'b110) ? -a_x : '0;
    term = mag << {cnt_q, 1'b0};
`ifdef BOOTH_EARLY_TERM_EN
    hi   = $signed(b_q) >>> {cnt_q, 1'b1};
    last = cnt_q == LAST || hi == '0 || &hi;
`else
    last = cnt_q == LAST;
`endif
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_prod_d  = out_prod_q;
    out_valid_d = out_valid_q;
    if (state_q == IDLE && in_valid) begin
      a_d     = in_signed ? {{2{in_a[WIDTH-1]}}, in_a} : {2'b00, in_a};
      b_d     = in_signed ? {{2{in_b[WIDTH-1]}}, in_b} : {2'b00, in_b};
      acc_d   = '0;
      cnt_d   = '0;
      state_d = BUSY;
    end else if (state_q == BUSY) begin
      acc_d = acc_q + term;
      cnt_d = cnt_q + CNT_W'(1);
      if (last) begin
        out_prod_d  = acc_d[2*WIDTH-1:0];
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
    end else if (state_q == DONE && out_ready) begin
      out_valid_d = 1'b0;
      state_d     = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_prod_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_prod_q  <= out_prod_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_booth_radix4_seq_mult.sv
// tb_booth_radix4_seq_mult: directed + random checks against an arithmetic product/latency model.
module tb_booth_radix4_seq_mult;
  localparam int W = 8;
  localparam int D = W/2+1;
  localparam bit ET = `ifdef BOOTH_EARLY_TERM_EN 1'b1 `else 1'b0 `endif;
  logic clk = 0, rst = 1, in_valid = 0, in_signed = 0, out_ready = 1;
  logic in_ready, out_valid;
  logic [W-1:0] in_a = 0, in_b = 0;
  logic [2*W-1:0] out_prod;
  int checks = 0, failures = 0, dut_del = 0, n_del = 0, m_wait = 0;
  bit m_busy = 0, m_valid = 0, rand_on = 0;
  logic [2*W-1:0] m_prod = 0, m_next = 0;

  booth_radix4_seq_mult #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
    .in_b(in_b), .in_signed(in_signed), .out_valid(out_valid), .out_ready(out_ready),
    .out_prod(out_prod)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] gold(logic [W-1:0] a, logic [W-1:0] b, logic s);
    logic signed [2*W-1:0] sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (s) return 16'(sa * sb);
    return {8'h00, a} * {8'h00, b};
  endfunction

  // cycles from accept to out_valid: first digit after which the rest of B' is pure sign
  function automatic int lat(logic [W-1:0] b, logic s);
    int bv;
    bv = s ? int'($signed(b)) : int'(b);
    if (!ET) return D;
    for (int i = 0; i <= W/2; i++)
      if ((bv >>> (2*i+1)) == 0 || (bv >>> (2*i+1)) == -1) return i+1;
    return D;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 0; m_valid <= 0; m_wait <= 0; m_prod <= 0;
    end else if (m_busy) begin
      if (m_wait == 1) begin
        m_busy <= 0; m_valid <= 1; m_prod <= m_next;
      end else m_wait <= m_wait - 1;
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid <= 0; n_del <= n_del + 1;
      end
    end else if (in_valid) begin
      m_busy <= 1; m_wait <= lat(in_b, in_signed); m_next <= gold(in_a, in_b, in_signed);
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("cyc_valid", out_valid, m_valid);
      if (m_valid) check("cyc_prod", out_prod, m_prod);
      check("cyc_ready", in_ready, !rst && !m_busy && !m_valid);
      if (out_valid && out_ready) dut_del++;
    end
  end

  task automatic txn(string name, logic [W-1:0] a, logic [W-1:0] b, logic s,
                     logic [2*W-1:0] ep, int el, int hold);
    int n;
    logic [2*W-1:0] p;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    check({name, "_ready"}, in_ready, 1);
    in_a = a; in_b = b; in_signed = s; in_valid = 1; out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 0; in_a = ~a; in_b = ~b; in_signed = ~s;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!out_valid && n < 20);
    check({name, "_lat"}, n, el);
    check({name, "_prod"}, out_prod, ep);
    p = out_prod;
    repeat (hold) begin
      in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      check({name, "_hold_valid"}, out_valid, 1);
      check({name, "_hold_prod"}, out_prod, p);
      check({name, "_hold_ready"}, in_ready, 0);
    end
    out_ready = 1;
    @(posedge clk); #1;
    check({name, "_drop"}, out_valid, 0);
    check({name, "_idle"}, in_ready, 1);
  endtask

  initial begin
    int n, base;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_prod", out_prod, 0);
    check("rst_ready", in_ready, 0);
    rst = 0;
    @(posedge clk); #1;
    txn("s_min_min", 8'h80, 8'h80, 1, 16'h4000, ET ? 4 : 5, 0);
    txn("s_7_m3", 8'd7, 8'hFD, 1, 16'hFFEB, ET ? 2 : 5, 0);
    txn("u_255_255", 8'hFF, 8'hFF, 0, 16'hFE01, 5, 0);
    txn("u_200_3", 8'd200, 8'd3, 0, 16'h0258, ET ? 2 : 5, 0);
    txn("s_m1_m1", 8'hFF, 8'hFF, 1, 16'h0001, ET ? 1 : 5, 0);
    txn("s_3_5", 8'd3, 8'd5, 1, 16'h000F, ET ? 2 : 5, 0);
    txn("s_3_m1", 8'd3, 8'hFF, 1, 16'hFFFD, ET ? 1 : 5, 0);
    txn("u_zero", 8'd0, 8'd0, 0, 16'h0000, ET ? 1 : 5, 0);
    txn("bp", 8'd13, 8'd11, 0, 16'h008F, ET ? 3 : 5, 6);
    txn("after_bp", 8'hF6, 8'd9, 1, 16'hFFA6, ET ? 3 : 5, 0);
    in_a = 8'hFF; in_b = 8'hFF; in_signed = 0; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_prod", out_prod, 0);
    rst = 0;
    repeat (8) begin @(posedge clk); #1; check("midrst_none", out_valid, 0); end
    check("midrst_ready", in_ready, 1);
    base = n_del;
    rand_on = 1;
    fork
      while (rand_on) begin @(posedge clk); #1; out_ready = $urandom_range(0, 3) != 0; end
      begin
        for (int t = 0; t < 1500; t++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          in_a = W'($urandom); in_b = W'($urandom); in_signed = 1'($urandom);
          in_valid = 1;
          n = 0;
          while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
          if (n == 100) check("rand_accept_timeout", n, 0);
          @(posedge clk); #1;
          in_valid = 0;
        end
        rand_on = 0;
      end
    join
    out_ready = 1;
    repeat (20) @(posedge clk);
    #1;
    check("rand_count", n_del - base, 1500);
    check("deliveries", dut_del, n_del);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
